// File: rtl/axi_stream_pckg.sv
// Shared types and helpers for the AXI-Stream slave write packer.
package axi_stream_pckg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_RECV,
        RX_DRAIN,
        RX_DONE,
        RX_DROP
    } rx_state_e;

    // Default destination TIDs as wired by the PS DMA driver.
    localparam int unsigned TID_WEIGHTS = 0;
    localparam int unsigned TID_BIAS    = 1;
    localparam int unsigned TID_INPUTS  = 2;

    function automatic int unsigned pack_ratio(input int unsigned vlw_wdt,
                                               input int unsigned beat_wdt,
                                               input logic        narrow);
        return narrow ? 1 : vlw_wdt / beat_wdt;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata shows the head entry whenever not empty.
module axis_sync_fifo #(
    parameter int unsigned WDT   = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WDT-1:0]             wdata,
    input  logic                       pop,
    output logic [WDT-1:0]             rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_WDT = $clog2(DEPTH);

    logic [WDT-1:0]     mem [DEPTH];
    logic [PTR_WDT-1:0] wptr;
    logic [PTR_WDT-1:0] rptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_WDT + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_slave_wr_packer.sv
// AXI-Stream slave that buffers a packet and packs beats into memory words per channel.
// Optional status outputs (ch_word_cnt, err_sticky) are enabled by AXIS_SLV_PACK_STATUS_EN.
module axis_slave_wr_packer
    import axi_stream_pckg::*;
#(
    parameter int unsigned      S_TDATA_WDT    = 32,
    parameter int unsigned      VLW_WDT        = 128,
    parameter int unsigned      FIFO_DEPTH     = 16,
    parameter int unsigned      N_CH           = 3,
    parameter int unsigned      TID_WDT        = 2,
    parameter int unsigned      ADDR_WDT       = 10,
    parameter logic [N_CH-1:0]  CH_NARROW_MASK = 3'b010
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_TDATA_WDT-1:0]  S_AXIS_TDATA,
    input  logic [TID_WDT-1:0]      S_AXIS_TID,
    input  logic                    S_AXIS_TLAST,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    input  logic                    rx_allow,
    output logic [N_CH-1:0]         mem_wr_en,
    output logic [ADDR_WDT-1:0]     mem_addr,
    output logic [VLW_WDT-1:0]      mem_data,
    output logic [N_CH-1:0]         ch_busy,
    output logic [N_CH-1:0]         ch_done,
    output logic                    rx_err
`ifdef AXIS_SLV_PACK_STATUS_EN
    ,
    output logic [N_CH*ADDR_WDT-1:0] ch_word_cnt,
    output logic                     err_sticky
`endif
);

    localparam int unsigned MAX_RATIO = VLW_WDT / S_TDATA_WDT;
    localparam int unsigned CNT_WDT   = $clog2(MAX_RATIO + 1);
    localparam int unsigned FIFO_WDT  = S_TDATA_WDT + 1;

    rx_state_e                  state;
    logic [TID_WDT-1:0]         cur_tid;
    logic [N_CH-1:0]            cur_onehot;
    logic                       tid_ok;
    logic                       start;
    logic                       beat_acc;

    logic                       push;
    logic                       pop;
    logic [FIFO_WDT-1:0]        fifo_rdata;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [CNT_WDT-1:0]         pack_cnt;
    logic [VLW_WDT-1:0]         word_acc;
    logic [VLW_WDT-1:0]         word_next;
    logic [ADDR_WDT-1:0]        addr;
    logic                       last_written;
    logic                       emit;
    int unsigned                ratio;
    int unsigned                shamt;

    // TREADY depends only on registered state and FIFO count.
    always_comb begin
        S_AXIS_TREADY = 1'b0;
        case (state)
            RX_RECV: S_AXIS_TREADY = !fifo_full;
            RX_DROP: S_AXIS_TREADY = 1'b1;
            default: S_AXIS_TREADY = 1'b0;
        endcase
    end

    assign beat_acc   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign push       = beat_acc && (state == RX_RECV);
    assign pop        = !fifo_empty;
    assign tid_ok     = 32'(S_AXIS_TID) < N_CH;
    assign start      = (state == RX_IDLE) && S_AXIS_TVALID && rx_allow && tid_ok;
    assign cur_onehot = N_CH'(1) << cur_tid;

    axis_sync_fifo #(
        .WDT   (FIFO_WDT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // First beat of a word lands in the MSB slot; later beats fill downwards.
    always_comb begin
        ratio     = pack_ratio(VLW_WDT, S_TDATA_WDT, CH_NARROW_MASK[cur_tid]);
        shamt     = VLW_WDT - S_TDATA_WDT * (32'(pack_cnt) + 1);
        word_next = word_acc | (VLW_WDT'(fifo_rdata[S_TDATA_WDT-1:0]) << shamt);
        emit      = pop && (fifo_rdata[S_TDATA_WDT] || (32'(pack_cnt) + 1 == ratio));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            cur_tid <= '0;
            ch_busy <= '0;
            ch_done <= '0;
            rx_err  <= 1'b0;
`ifdef AXIS_SLV_PACK_STATUS_EN
            ch_word_cnt <= '0;
            err_sticky  <= 1'b0;
`endif
        end else begin
            ch_done <= '0;
            rx_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (S_AXIS_TVALID && rx_allow) begin
                        cur_tid <= S_AXIS_TID;
                        if (tid_ok) begin
                            state   <= RX_RECV;
                            ch_busy <= N_CH'(1) << S_AXIS_TID;
                        end else begin
                            state <= RX_DROP;
                        end
                    end
                end
                RX_RECV: begin
                    if (push && S_AXIS_TLAST) begin
                        state <= RX_DRAIN;
                    end
                end
                RX_DRAIN: begin
                    if (fifo_count == '0 && last_written) begin
                        state   <= RX_DONE;
                        ch_done <= cur_onehot;
`ifdef AXIS_SLV_PACK_STATUS_EN
                        ch_word_cnt[32'(cur_tid)*ADDR_WDT +: ADDR_WDT] <= addr;
`endif
                    end
                end
                RX_DONE: begin
                    state   <= RX_IDLE;
                    ch_busy <= '0;
                end
                RX_DROP: begin
                    if (beat_acc && S_AXIS_TLAST) begin
                        state  <= RX_IDLE;
                        rx_err <= 1'b1;
`ifdef AXIS_SLV_PACK_STATUS_EN
                        err_sticky <= 1'b1;
`endif
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_cnt     <= '0;
            word_acc     <= '0;
            addr         <= '0;
            last_written <= 1'b0;
            mem_wr_en    <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
        end else begin
            mem_wr_en <= '0;
            if (start) begin
                pack_cnt     <= '0;
                word_acc     <= '0;
                addr         <= '0;
                last_written <= 1'b0;
            end else if (pop) begin
                if (emit) begin
                    mem_wr_en    <= cur_onehot;
                    mem_addr     <= addr;
                    mem_data     <= word_next;
                    addr         <= addr + 1'b1;
                    word_acc     <= '0;
                    pack_cnt     <= '0;
                    last_written <= fifo_rdata[S_TDATA_WDT];
                end else begin
                    word_acc <= word_next;
                    pack_cnt <= pack_cnt + 1'b1;
                end
            end
        end
    end

endmodule
